operand_src: RTL and testbench
==============================

OPERAND_SRC -- requirements
Module: operand_src

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter DEPTH, default 4, operand-pair FIFO depth; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start_i  input  1  level; begin or resume emission.
REQ-006 stop_i  input  1  level; halt emission.
REQ-007 interval_i  input  4  idle cycles inserted between emitted pairs; 0 means back-to-back.
REQ-008 push_valid_i  input  1  producer offers a pair.
REQ-009 push_ready_o  output  1  FIFO can accept a pair.
REQ-010 push_a_i, push_b_i  input  WIDTH each  offered operand pair.
REQ-011 a_o, b_o  output  WIDTH each  registered operands driven to the downstream register stage (a_i/b_i).
REQ-012 out_valid_o  output  1  a_o/b_o were updated at the most recent edge.
REQ-013 busy_o  output  1  FSM is not in IDLE.
REQ-014 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Push is accepted at an edge when push_valid_i and push_ready_o are both high; push_ready_o shall be high exactly when count_o < DEPTH, with no same-cycle bypass on full.
REQ-016 Pushes offered while push_ready_o is low shall be ignored without side effects.
REQ-017 The FSM states shall be IDLE, RUN and WAIT.
REQ-018 IDLE: no emission; FIFO still accepts pushes; start_i high goes to RUN next edge.
REQ-019 RUN with count_o > 0: the FSM shall pop the FIFO head into a_o/b_o at that edge, assert out_valid_o for the following cycle, and enter WAIT with counter = interval_i if interval_i != 0, otherwise stay in RUN.
REQ-020 RUN with count_o = 0: no emission, unless the REQ-034 feature is compiled in.
REQ-021 WAIT: the counter shall decrement each edge, and the FSM shall return to RUN at the edge where the counter equals 1.
REQ-022 interval_i is sampled only on entering WAIT.
REQ-023 stop_i high shall force IDLE at the next edge from any state, with priority over start_i.
REQ-024 stop_i shall preserve FIFO contents and a_o/b_o.
REQ-025 A simultaneous push and pop shall leave count_o unchanged; pop always takes the head, pushes go to the tail, and order is strictly FIFO.
REQ-026 Read and write pointers shall wrap modulo DEPTH.
REQ-027 Latency: a pair accepted at edge N into an empty FIFO while in RUN with no pending interval shall appear on a_o/b_o at edge N+1.
REQ-028 a_o/b_o shall hold their last value whenever out_valid_o is low.
REQ-029 out_valid_o shall be a single-cycle pulse per emitted pair.

Reset
REQ-030 With rst high at an edge, the block shall enter IDLE, clear the FIFO pointers, set count_o=0, a_o=0, b_o=0, out_valid_o=0 and busy_o=0, and clear the WAIT counter.
REQ-031 Reset shall take priority over push, start_i and stop_i, and shall discard any pair in flight mid-operation.
REQ-032 push_ready_o shall be 1 in the first cycle after reset.

Configuration
REQ-033 Macro OPERAND_SRC_LFSR_EN shall control the free-running fallback.
REQ-034 With OPERAND_SRC_LFSR_EN defined: WIDTH shall be 8; a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded 16'hACE1 at reset; in RUN with the FIFO empty, the block shall emit a_o=lfsr[15:8], b_o=lfsr[7:0] with the same pacing and out_valid_o rules; the LFSR advances only on an LFSR emission.
REQ-035 Without OPERAND_SRC_LFSR_EN: no LFSR logic is present, and RUN with an empty FIFO emits nothing.

Verification
REQ-036 Reset then push (3,5),(7,9) in IDLE, start, interval 0 -> count_o=2 before start; outputs (3,5) then (7,9) on consecutive cycles; out_valid_o high 2 cycles.
REQ-037 Push 5 pairs back-to-back with DEPTH=4 in IDLE -> first 4 accepted, push_ready_o low on the 5th; count_o=4; the 5th pair is never emitted.
REQ-038 RUN, interval 3, FIFO holds (1,2),(3,4) -> out_valid_o pulses 4 cycles apart; a_o=1 then a_o=3.
REQ-039 FIFO full, RUN, push held high continuously -> push_ready_o=0 until the pop; count_o steps 4->3; the next push is accepted the following cycle; order preserved.
REQ-040 stop_i and start_i both high during emission, then rst mid-WAIT -> IDLE after one edge with contents kept; after rst: count_o=0, a_o=b_o=0, busy_o=0.
REQ-041 OPERAND_SRC_LFSR_EN defined, RUN with empty FIFO, interval 0 -> first emission a_o=8'hAC, b_o=8'hE1, followed by successive LFSR states each cycle.

Source files
------------

// File: rtl/operand_src.sv
// Operand pair source: small FIFO feeding a paced IDLE/RUN/WAIT emitter onto registered a_o/b_o.
// Define OPERAND_SRC_LFSR_EN to emit 16-bit LFSR operands whenever RUN finds the FIFO empty (WIDTH must be 8).
module operand_src #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [3:0]                 interval_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [WIDTH-1:0]           push_a_i,
    input  logic [WIDTH-1:0]           push_b_i,
    output logic [WIDTH-1:0]           a_o,
    output logic [WIDTH-1:0]           b_o,
    output logic                       out_valid_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [1:0]                 state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Push side: a pair moves when push_valid_i and push_ready_o are both high at a rising edge.
    // push_ready_o depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic                 push_ready;
    logic                 push_fire;
    logic                 pop_fire;
    logic                 emit;
`ifdef OPERAND_SRC_LFSR_EN
    logic [15:0]          lfsr_q, lfsr_d;
`endif

    assign push_ready = (count_q < CW'(DEPTH));
    assign push_fire  = push_valid_i && push_ready;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        pop_fire    = 1'b0;
        emit        = 1'b0;
`ifdef OPERAND_SRC_LFSR_EN
        lfsr_d      = lfsr_q;
`endif
        // stop_i wins over everything and freezes FIFO, counter and outputs.
        if (stop_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) state_d = S_RUN;
                end
                S_RUN: begin
                    if (count_q != '0) begin
                        pop_fire   = 1'b1;
                        emit       = 1'b1;
                        {a_d, b_d} = mem_q[rd_ptr_q];
                    end
`ifdef OPERAND_SRC_LFSR_EN
                    else begin
                        emit   = 1'b1;
                        a_d    = WIDTH'(lfsr_q[15:8]);
                        b_d    = WIDTH'(lfsr_q[7:0]);
                        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    end
`endif
                    if (emit && interval_i != 4'd0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = interval_i;
                    end
                end
                S_WAIT: begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
        out_valid_d = emit;
        rd_ptr_d    = rd_ptr_q + AW'(pop_fire);
        wr_ptr_d    = wr_ptr_q + AW'(push_fire);
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef OPERAND_SRC_LFSR_EN
            lfsr_q      <= 16'hACE1;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
`ifdef OPERAND_SRC_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) mem_q[wr_ptr_q] <= {push_a_i, push_b_i};
    end

    assign push_ready_o = push_ready;
    assign a_o          = a_q;
    assign b_o          = b_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign count_o      = count_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_operand_src.sv
// Bench for operand_src: directed scenarios then random traffic, checked against a queue-based pacing model.
// Define OPERAND_SRC_LFSR_EN for both files to also cover the LFSR fallback.
module tb_operand_src;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic [3:0]       interval_i = 4'd0;
    logic             push_valid_i = 1'b0;
    logic             push_ready_o;
    logic [WIDTH-1:0] push_a_i = '0;
    logic [WIDTH-1:0] push_b_i = '0;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             out_valid_o;
    logic             busy_o;
    logic [CW-1:0]    count_o;
    logic [1:0]       state_o;

    always #5 clk = ~clk;

    operand_src #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .interval_i(interval_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_a_i(push_a_i), .push_b_i(push_b_i),
        .a_o(a_o), .b_o(b_o), .out_valid_o(out_valid_o), .busy_o(busy_o),
        .count_o(count_o), .state_o(state_o)
    );

    // Reference model: queue of pending pairs, a running flag and a number of cycles still to sit out.
    logic [2*WIDTH-1:0] exp_q[$];
    bit                 m_run;
    int                 m_hold;
    logic [WIDTH-1:0]   m_a, m_b;
    bit                 m_valid;
    logic [15:0]        m_lfsr;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
        // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_edge();
        bit may_emit;
        bit push_ok;
        if (rst) begin
            exp_q.delete();
            m_run = 0; m_hold = 0; m_a = '0; m_b = '0; m_valid = 0; m_lfsr = 16'hACE1;
        end else begin
            may_emit = m_run && !stop_i && m_hold == 0;
            push_ok  = push_valid_i && exp_q.size() < DEPTH;
            m_valid  = 0;
            if (may_emit && exp_q.size() > 0) begin
                {m_a, m_b} = exp_q.pop_front();
                m_valid = 1;
            end
`ifdef OPERAND_SRC_LFSR_EN
            else if (may_emit) begin
                m_a = m_lfsr[15:8];
                m_b = m_lfsr[7:0];
                m_lfsr = lfsr_advance(m_lfsr);
                m_valid = 1;
            end
`endif
            if (m_valid) m_hold = int'(interval_i);
            else if (m_run && !stop_i && m_hold > 0) m_hold--;
            if (stop_i) m_hold = 0;
            if (push_ok) exp_q.push_back({push_a_i, push_b_i});
            m_run = stop_i ? 0 : (start_i ? 1 : m_run);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input logic [3:0] iv,
                        input bit pv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        rst = r; start_i = s; stop_i = p; interval_i = iv;
        push_valid_i = pv; push_a_i = a; push_b_i = b;
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid_o), 32'(m_valid));
        chk("a_o", 32'(a_o), 32'(m_a));
        chk("b_o", 32'(b_o), 32'(m_b));
        chk("count", 32'(count_o), 32'(exp_q.size()));
        chk("push_ready", 32'(push_ready_o), 32'(exp_q.size() < DEPTH));
        chk("busy", 32'(busy_o), 32'(m_run));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Two back-to-back pairs with interval 0
        do_reset();
        step(0, 0, 0, 0, 1, 3, 5);
        step(0, 0, 0, 0, 1, 7, 9);
        chk("pre_start_count", 32'(count_o), 32'd2);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Overfill in IDLE: fifth pair dropped
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'(10 + i), 8'(20 + i));
        chk("full_count", 32'(count_o), 32'd4);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Interval 3 pacing
        do_reset();
        step(0, 0, 0, 3, 1, 1, 2);
        step(0, 0, 0, 3, 1, 3, 4);
        step(0, 1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 3, 0, 0, 0);

        // Full FIFO with push held high while draining
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'(40 + i), 8'(50 + i));
        step(0, 1, 0, 2, 1, 8'h60, 8'h70);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 2, 1, 8'(97 + i), 8'(113 + i));

        // stop+start together during emission, resume, then reset mid-WAIT
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3, 1, 8'(80 + i), 8'(90 + i));
        step(0, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 3, 0, 0, 0);
        step(0, 1, 1, 3, 0, 0, 0);
        step(0, 0, 0, 3, 0, 0, 0);
        step(0, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 3, 0, 0, 0);
        step(1, 1, 0, 3, 1, 8'hEE, 8'hEE);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_a", 32'(a_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

`ifdef OPERAND_SRC_LFSR_EN
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lfsr_first_a", 32'(a_o), 32'h00AC);
        chk("lfsr_first_b", 32'(b_o), 32'h00E1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0,
                 4'($urandom_range(0, 5)),
                 $urandom_range(0, 2) != 0,
                 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
